// File: rtl/scpad_fe_arbiter.sv
// scpad_fe_arbiter: round-robin arbiter sharing one scratchpad body request
// port among NUM_REQ frontends. An in-order tag FIFO routes each body
// response back to the frontend that issued the request.
// Optional build macro: SCPAD_ARB_PERF_CNT_EN adds saturating performance
// counters (grant_cnt, conflict_cnt, full_cnt).
module scpad_fe_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned REQ_W   = 32,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       vec_req_valid,
  input  logic [NUM_REQ*REQ_W-1:0] vec_req,
  output logic [NUM_REQ-1:0]       vec_stall,
  output logic [NUM_REQ-1:0]       vec_res_valid,
  output logic [RES_W-1:0]         vec_res,
  input  logic                     body_stall,
  output logic                     body_req_valid,
  output logic [REQ_W-1:0]         body_req,
  input  logic                     body_res_valid,
  input  logic [RES_W-1:0]         body_res,
  output logic                     err_orphan
`ifdef SCPAD_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]    grant_cnt,
  output logic [31:0]              conflict_cnt,
  output logic [31:0]              full_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   tag_q [DEPTH];

  logic               body_req_valid_q;
  logic [REQ_W-1:0]   body_req_q;
  logic [NUM_REQ-1:0] vec_res_valid_q, vec_res_valid_d;
  logic [RES_W-1:0]   vec_res_q;
  logic               err_orphan_q;

  logic               can_issue;
  logic [NUM_REQ-1:0] upper_req;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [REQ_W-1:0]   win_req;
  logic               pop;

  // Reset also blocks issue so frontends see a full stall during reset.
  assign can_issue = !rst && !body_stall && (count_q < DEPTH_C);
  assign pop       = !rst && body_res_valid && (count_q != '0);

  // Round-robin winner: first valid at or above rr_q, else wrap to the lowest valid.
  always_comb begin
    upper_req = '0;
    found     = 1'b0;
    win       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      upper_req[i] = vec_req_valid[i] && (IDX_W'(i) >= rr_q);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && upper_req[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && vec_req_valid[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end

  // Grant vector, winning payload, stalls and next round-robin pointer.
  always_comb begin
    grant_any = can_issue && found;
    grant     = '0;
    win_req   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (win == IDX_W'(i))) begin
        grant[i] = 1'b1;
        win_req  = vec_req[i*REQ_W +: REQ_W];
      end
    end
    vec_stall = vec_req_valid & ~grant;
    rr_d      = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  // Outstanding count and one-hot routing of the popped head tag.
  always_comb begin
    count_d = count_q;
    if (grant_any && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!grant_any && pop) begin
      count_d = count_q - 1'b1;
    end
    vec_res_valid_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      vec_res_valid_d[i] = pop && (tag_q[rd_q] == IDX_W'(i));
    end
  end

  // Tag storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      tag_q[wr_q] <= win;
    end
  end

  // Request register, FIFO pointers, response register and orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q             <= '0;
      wr_q             <= '0;
      rd_q             <= '0;
      count_q          <= '0;
      body_req_valid_q <= 1'b0;
      body_req_q       <= '0;
      vec_res_valid_q  <= '0;
      vec_res_q        <= '0;
      err_orphan_q     <= 1'b0;
    end else begin
      // A stalled body keeps the previous request presented unchanged.
      if (!body_stall) begin
        body_req_valid_q <= grant_any;
      end
      if (grant_any) begin
        body_req_q <= win_req;
        rr_q       <= rr_d;
        wr_q       <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q      <= rd_q + 1'b1;
        vec_res_q <= body_res;
      end
      count_q         <= count_d;
      vec_res_valid_q <= vec_res_valid_d;
      if (body_res_valid && (count_q == '0)) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

  assign body_req_valid = body_req_valid_q;
  assign body_req       = body_req_q;
  assign vec_res_valid  = vec_res_valid_q;
  assign vec_res        = vec_res_q;
  assign err_orphan     = err_orphan_q;

`ifdef SCPAD_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] conflict_cnt_q;
  logic [31:0] full_cnt_q;
  logic        multi_valid;

  // Two or more requesters valid: clearing the lowest set bit leaves something.
  assign multi_valid = |(vec_req_valid & (vec_req_valid - 1'b1));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
      conflict_cnt_q <= '0;
      full_cnt_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt_q[i] != '1)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
      end
      if (multi_valid && can_issue && (conflict_cnt_q != '1)) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
      if ((count_q == DEPTH_C) && (|vec_req_valid) && (full_cnt_q != '1)) begin
        full_cnt_q <= full_cnt_q + 32'd1;
      end
    end
  end

  // Flatten per-requester counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*32 +: 32] = grant_cnt_q[i];
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign full_cnt     = full_cnt_q;
`endif

endmodule

// File: tb/tb_scpad_fe_arbiter.sv
// Testbench for scpad_fe_arbiter: table of per-cycle stimulus with hand-derived
// stall/grant expectations, a response-tag model and an expected-output queue.
module tb_scpad_fe_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned RW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     vec_req_valid = '0;
  logic [NR*RW-1:0]  vec_req = '0;
  logic [NR-1:0]     vec_stall;
  logic [NR-1:0]     vec_res_valid;
  logic [RW-1:0]     vec_res;
  logic              body_stall = 1'b0;
  logic              body_req_valid;
  logic [RW-1:0]     body_req;
  logic              body_res_valid = 1'b0;
  logic [RW-1:0]     body_res = '0;
  logic              err_orphan;
`ifdef SCPAD_ARB_PERF_CNT_EN
  logic [NR*32-1:0]  grant_cnt;
  logic [31:0]       conflict_cnt;
  logic [31:0]       full_cnt;
`endif

  scpad_fe_arbiter #(
    .NUM_REQ(NR),
    .REQ_W  (RW),
    .RES_W  (RW),
    .DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vec_req_valid (vec_req_valid),
    .vec_req       (vec_req),
    .vec_stall     (vec_stall),
    .vec_res_valid (vec_res_valid),
    .vec_res       (vec_res),
    .body_stall    (body_stall),
    .body_req_valid(body_req_valid),
    .body_req      (body_req),
    .body_res_valid(body_res_valid),
    .body_res      (body_res),
    .err_orphan    (err_orphan)
`ifdef SCPAD_ARB_PERF_CNT_EN
    ,
    .grant_cnt     (grant_cnt),
    .conflict_cnt  (conflict_cnt),
    .full_cnt      (full_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [1:0] v;
    logic       bs;
    logic       rv;
    logic [1:0] st;
    int         g;
  } vec_t;

  typedef struct {
    logic          brv;
    logic [RW-1:0] breq;
    logic [NR-1:0] rv;
    logic [RW-1:0] res;
    logic          orph;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tags[$];

  int checks = 0;
  int errors = 0;

  logic          m_brv;
  logic [RW-1:0] m_breq;
  logic [RW-1:0] m_res;
  logic          m_orph;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] v, input logic bs, input logic rv,
                     input logic [1:0] st, input int g);
    vec_t r;
    r.nm = nm; r.v = v; r.bs = bs; r.rv = rv; r.st = st; r.g = g;
    tbl.push_back(r);
  endtask

  // Reset with all requesters valid; entered and left at a negedge.
  task automatic do_reset();
    rst            = 1'b1;
    vec_req_valid  = 2'b11;
    vec_req        = $urandom;
    body_stall     = 1'b0;
    body_res_valid = 1'b0;
    #1;
    chk("rst_stall", 32'(vec_stall), 32'h3);
    @(posedge clk);
    #1;
    chk("rst_brv",  32'(body_req_valid), 32'h0);
    chk("rst_breq", 32'(body_req), 32'h0);
    chk("rst_vrv",  32'(vec_res_valid), 32'h0);
    chk("rst_vres", 32'(vec_res), 32'h0);
    chk("rst_orph", 32'(err_orphan), 32'h0);
    tags.delete();
    m_brv = 1'b0; m_breq = '0; m_res = '0; m_orph = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: drive at negedge, check stall before the edge, outputs after it.
  task automatic step(input string nm, input logic [1:0] v, input logic bs, input logic rv,
                      input logic [1:0] exp_stall, input int exp_g);
    exp_t          e;
    logic [31:0]   pay;
    logic [RW-1:0] rd;
    int            t;
    pay = $urandom;
    rd  = RW'($urandom);
    rst            = 1'b0;
    vec_req_valid  = v;
    vec_req        = pay;
    body_stall     = bs;
    body_res_valid = rv;
    body_res       = rd;
    #1;
    chk({nm, "_stall"}, 32'(vec_stall), 32'(exp_stall));
    e.rv = '0;
    if (rv) begin
      if (tags.size() != 0) begin
        t     = tags.pop_front();
        e.rv  = NR'(1) << t;
        m_res = rd;
      end else begin
        m_orph = 1'b1;
      end
    end
    if (exp_g >= 0) begin
      m_brv  = 1'b1;
      m_breq = RW'(pay >> (RW * exp_g));
      tags.push_back(exp_g);
    end else if (!bs) begin
      m_brv = 1'b0;
    end
    e.brv = m_brv; e.breq = m_breq; e.res = m_res; e.orph = m_orph;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, "_brv"},  32'(body_req_valid), 32'(e.brv));
    chk({nm, "_breq"}, 32'(body_req), 32'(e.breq));
    chk({nm, "_vrv"},  32'(vec_res_valid), 32'(e.rv));
    chk({nm, "_vres"}, 32'(vec_res), 32'(e.res));
    chk({nm, "_orph"}, 32'(err_orphan), 32'(e.orph));
    @(negedge clk);
  endtask

  initial begin
    // name, valid, body_stall, res_valid, expected stall, expected grant (-1 none)
    add("fair0", 2'b11, 1'b0, 1'b0, 2'b10,  0);
    add("fair1", 2'b11, 1'b0, 1'b1, 2'b01,  1);
    add("fair2", 2'b11, 1'b0, 1'b1, 2'b10,  0);
    add("fair3", 2'b11, 1'b0, 1'b1, 2'b01,  1);
    add("fair4", 2'b11, 1'b0, 1'b1, 2'b10,  0);
    add("fair5", 2'b11, 1'b0, 1'b1, 2'b01,  1);
    add("bst0",  2'b11, 1'b1, 1'b0, 2'b11, -1);
    add("bst1",  2'b11, 1'b1, 1'b0, 2'b11, -1);
    add("bst2",  2'b11, 1'b1, 1'b0, 2'b11, -1);
    add("bres",  2'b11, 1'b0, 1'b0, 2'b10,  0);
    add("drn0",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("drn1",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("fill0", 2'b01, 1'b0, 1'b0, 2'b00,  0);
    add("fill1", 2'b10, 1'b0, 1'b0, 2'b00,  1);
    add("fill2", 2'b11, 1'b0, 1'b0, 2'b10,  0);
    add("fill3", 2'b10, 1'b0, 1'b0, 2'b00,  1);
    add("full",  2'b11, 1'b0, 1'b0, 2'b11, -1);
    add("fpop",  2'b11, 1'b0, 1'b1, 2'b11, -1);
    add("fafter",2'b11, 1'b0, 1'b0, 2'b10,  0);
    add("fpop2", 2'b01, 1'b0, 1'b1, 2'b01, -1);
    add("fafter2",2'b01,1'b0, 1'b0, 2'b00,  0);
    add("drn2",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("drn3",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("drn4",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("drn5",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("iss1",  2'b10, 1'b0, 1'b0, 2'b00,  1);
    add("iss0",  2'b01, 1'b0, 1'b0, 2'b00,  0);
    add("iss1b", 2'b10, 1'b0, 1'b0, 2'b00,  1);
    add("resA",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("resB",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("resC",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("orph",  2'b00, 1'b0, 1'b1, 2'b00, -1);
    add("post0", 2'b11, 1'b0, 1'b0, 2'b10,  0);
    add("post1", 2'b00, 1'b0, 1'b1, 2'b00, -1);

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].nm, tbl[i].v, tbl[i].bs, tbl[i].rv, tbl[i].st, tbl[i].g);
    end

    // Reset with two requests outstanding: the late response becomes an orphan.
    step("mid0", 2'b11, 1'b0, 1'b0, 2'b01, 1);
    step("mid1", 2'b01, 1'b0, 1'b0, 2'b00, 0);
    do_reset();
    step("lateres", 2'b00, 1'b0, 1'b1, 2'b00, -1);
    step("rrrst",   2'b11, 1'b0, 1'b0, 2'b10,  0);
    step("rrnext",  2'b11, 1'b0, 1'b0, 2'b01,  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scpad_fe_arbiter.md
# scpad_fe_arbiter

Shares the single scratchpad body request port among `NUM_REQ` vector-core frontends. The arbiter picks at most one valid request per cycle with round-robin priority and registers it towards the body. It records the winner's index in an in-order tag FIFO, then routes each body response back to the frontend that issued the request. The block sits between the frontend pipeline latches and the scratchpad body, and produces the per-frontend stall signals.

## Interface
- `NUM_REQ`, default 2: number of frontend requesters (2..8).
- `REQ_W`, default `$bits(req_t)`: request payload width.
- `RES_W`, default `$bits(res_t)`: response payload width.
- `DEPTH`, default 4: maximum outstanding requests (power of two, ≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `vec_req_valid` in `NUM_REQ`: frontend i has a request.
- `vec_req` in `NUM_REQ*REQ_W`: request payloads; slice i belongs to frontend i.
- `vec_stall` out `NUM_REQ`: frontend i must hold its request (combinational).
- `vec_res_valid` out `NUM_REQ`: response valid for frontend i (registered).
- `vec_res` out `RES_W`: response payload, shared by all frontends (registered).
- `body_stall` in 1: body cannot accept a new request this cycle.
- `body_req_valid` out 1: registered request valid towards the body.
- `body_req` out `REQ_W`: registered request payload.
- `body_res_valid` in 1: the body returns one response, in issue order.
- `body_res` in `RES_W`: response payload from the body.
- `err_orphan` out 1: sticky flag; a response arrived while no request was outstanding.

## Operation
- **Grant enable:** `can_issue = !body_stall && (count < DEPTH)`. No same-cycle bypass from a pop.
- **Winner selection:** when `can_issue` is set, the winner is the first valid requester scanning from `rr_ptr` upward, modulo `NUM_REQ`. `grant` is one-hot or zero.
- **Stall:** `vec_stall[i] = vec_req_valid[i] && !grant[i]`.
- **On grant to i:**
  - `body_req <= vec_req[i]` and `body_req_valid <= 1`.
  - Push i onto the tag FIFO.
  - `rr_ptr <= (i+1) mod NUM_REQ`.
- **`body_stall` high:** `body_req_valid` and `body_req` hold their values. No grant is issued and `rr_ptr` holds.
- **No grant and `body_stall` low:** `body_req_valid <= 0`. `body_req` keeps its last value.
- **`body_res_valid` with FIFO non-empty:**
  - Pop the head tag t.
  - Next cycle: `vec_res_valid` is one-hot at t and `vec_res = body_res`.
  - Otherwise `vec_res_valid = 0` and `vec_res` holds.
- **`body_res_valid` with FIFO empty:** no pop, no response is routed, and `err_orphan <= 1`. It clears only on reset.
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance.
- **Pointers:** read/write pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH)+1` bits.
- **Reset values:** `body_req_valid=0`, `body_req=0`, `vec_res_valid=0`, `vec_res=0`, `err_orphan=0`, `rr_ptr=0`, FIFO empty, `count=0`.
- **Reset mid-operation:** every outstanding tag is discarded. A response arriving after reset is an orphan.

## Timing
- Request accepted in cycle t (`grant[i]=1`) → `body_req_valid=1` with that payload in cycle t+1.
- Response at the body in cycle u → `vec_res_valid[tag]` in cycle u+1.
- Back-to-back grants are possible, one per cycle, while `can_issue` stays high.
- `vec_stall` follows `vec_req_valid`, `body_stall` and `count` within the same cycle.
- During the reset cycle, `vec_stall = vec_req_valid`.

## Configuration
- **`SCPAD_ARB_PERF_CNT_EN` defined:**
  - Adds output `grant_cnt` (`NUM_REQ*32` bits): per-requester 32-bit grant counters.
  - Adds output `conflict_cnt` (32 bits): increments each cycle where two or more requesters are valid and `can_issue` is high.
  - Adds output `full_cnt` (32 bits): increments each cycle where `count == DEPTH` and some request is valid.
  - All counters are zeroed by reset and saturate at 2^32−1.
- **Undefined:** these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- **Reset:** assert `rst` with all requesters valid → all outputs are zero and `vec_stall=2'b11`. Deassert `rst` → frontend 0 is granted first.
- **Fairness:** `NUM_REQ=2`, both valid for 6 cycles with no stall → grant sequence 0,1,0,1,0,1. `body_req` matches each payload one cycle after its grant.
- **Body stall:** `body_stall` high for 3 cycles mid-stream → `body_req` frozen, no grants, `rr_ptr` unchanged. The stream resumes with the next requester in order.
- **FIFO full:** 4 grants with no responses → the 5th valid request stalls. One response followed by a new request gives a grant in the cycle after the pop. A simultaneous response and request while full → no grant that cycle.
- **Response routing:** issue order 1,0,1, then 3 responses tagged A,B,C → `vec_res_valid` sequence 2'b10, 2'b01, 2'b10 with payloads A,B,C, each one cycle after its response.
- **Orphan response:** `body_res_valid` pulse when nothing is outstanding → `err_orphan=1` next cycle and held until reset. No `vec_res_valid` pulse. The perf build shows `grant_cnt` unchanged.
